mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction-fetch path and its load/store path.
- Sits between the PC/instruction-decode side and the data-access side of the RISC-V core, and the external memory port.
- Runs a small FSM that grants one requester at a time, holds the memory request stable until the memory answers, and returns data with a one-cycle valid pulse.
- Drives a stall to the core and flags memory timeouts.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width
- TIMEOUT, 255, max busy cycles without mem_ready before abort (1..2^16-1)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request, held high until if_valid seen
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held high until d_valid seen
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_valid  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion strobe
- stall  out  1  core must hold PC and register writes
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; wait counter 0; last_grant=IF; timeout_err=0.
  - Applies mid-transaction: mem_req drops immediately and the pending transaction is discarded with no valid pulse.
- States: IDLE, BUSY_IF, BUSY_D, RESP.
- IDLE: requests are sampled only in this state.
  - If only d_req=1: go to BUSY_D.
  - If only if_req=1: go to BUSY_IF.
  - If both are high: grant whichever was NOT last_grant, so data and fetch alternate and neither starves.
  - On grant: latch address, we and wdata into the mem_* registers, set mem_req=1, update last_grant, clear the counter.
  - A fetch grant always forces mem_we=0.
- BUSY_IF / BUSY_D:
  - mem_* outputs stay stable.
  - Each cycle with mem_ready=0 increments the counter.
  - mem_ready=1: capture mem_rdata into if_rdata (BUSY_IF) or d_rdata (BUSY_D, load only). mem_req=0 next cycle; go to RESP.
  - A store completion leaves d_rdata unchanged.
  - Counter reaching TIMEOUT with mem_ready=0: mem_req=0, set timeout_err, go to RESP. The rdata register for that requester loads 0.
- RESP: exactly one cycle.
  - Asserts if_valid or d_valid for the granted side.
  - Requests are ignored this cycle; go to IDLE.
  - Requesters must drop req on the edge ending the valid cycle.
- Latency: req sampled at edge E0 → mem_req high from E0 → mem_ready earliest in that cycle → valid in the following cycle. The minimum is 3 cycles from request to valid.
- mem_ready while in IDLE or RESP: ignored.
- stall (combinational) = (if_req & ~if_valid) | (d_req & ~d_valid).
- timeout_err stays 1 until reset.
- if_rdata and d_rdata hold their values between completions.
- Counter width is ceil(log2(TIMEOUT+1)) and never wraps, because it is cleared on every grant.

Test Plan:
- Reset mid-transaction:
  - Stimulus: if_req=1, if_addr=0x10, with reset pulsed low while in BUSY_IF.
  - Required: mem_req=0 within the reset cycle without waiting for an edge, no if_valid, state IDLE after release.
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x10, memory answers 0x00500093 with 1-cycle ready.
  - Required: mem_req=1/mem_we=0/mem_addr=0x10 for one cycle, then if_valid=1 with if_rdata=0x00500093. stall=1 until the valid cycle.
- Store then fetch, simultaneous:
  - Stimulus: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF and if_req=1 in the same IDLE cycle, last_grant=IF.
  - Required: data is granted first with mem_we=1, mem_wdata=0xDEADBEEF. After d_valid, the fetch is granted. d_rdata is unchanged.
- Alternation:
  - Stimulus: both requests kept asserted continuously for four transactions.
  - Required: grants ordered D, IF, D, IF. Exactly one valid pulse per transaction, never both valids high in the same cycle.
- Variable latency:
  - Stimulus: load of 0x44 with mem_ready delayed 5 cycles, mem_rdata=0x12345678.
  - Required: mem_addr stable at 0x44 for all 6 busy cycles, then d_valid with d_rdata=0x12345678.
- Timeout:
  - Stimulus: TIMEOUT=4, fetch issued with mem_ready held 0.
  - Required: after 4 busy cycles mem_req drops, if_valid pulses with if_rdata=0, and timeout_err=1. timeout_err stays high through later good transactions until reset=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to fetch or load/store, alternating when both ask; valid pulses one cycle after mem_ready.
// Minimum 3 cycles request-to-valid; requesters are stalled until their valid, memory stalls via mem_ready (bounded by TIMEOUT).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               last_d;
  logic               cnt_done;

  // The current busy cycle is the TIMEOUT-th one without mem_ready.
  assign cnt_done = (wait_cnt == CNT_W'(TIMEOUT - 1));

  assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      last_d      <= 1'b0;
      if_rdata    <= '0;
      if_valid    <= 1'b0;
      d_rdata     <= '0;
      d_valid     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req && (!if_req || !last_d)) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            last_d    <= 1'b1;
            wait_cnt  <= '0;
          end else if (if_req) begin
            state    <= BUSY_IF;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            last_d   <= 1'b0;
            wait_cnt <= '0;
          end
        end
        BUSY_IF, BUSY_D: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            state    <= RESP;
            if_valid <= (state == BUSY_IF);
            d_valid  <= (state == BUSY_D);
            if (state == BUSY_IF)
              if_rdata <= mem_rdata;
            else if (!mem_we)
              d_rdata <= mem_rdata;
          end else if (cnt_done) begin
            mem_req     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= RESP;
            if_valid    <= (state == BUSY_IF);
            d_valid     <= (state == BUSY_D);
            if (state == BUSY_IF)
              if_rdata <= '0;
            else
              d_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of grant order, latency and results.
module tb_mem_port_arbiter;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall, timeout_err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Requester-side view: pending requests and what the model expects back.
  bit          if_pend, d_pend, d_w;
  logic [31:0] if_a, d_a, d_wd;
  bit          last_if;
  logic [31:0] if_exp, d_exp;
  bit          tmo_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive_reqs();
    if_req  = if_pend;
    if_addr = if_a;
    d_req   = d_pend;
    d_we    = d_w;
    d_addr  = d_a;
    d_wdata = d_wd;
  endtask

  // Called one step after an edge with the DUT idle; runs one arbitration round.
  task automatic do_round(input int lat, input logic [31:0] rd);
    bit g_d, to;
    int n;
    drive_reqs();
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    chk("stall_idle", stall, if_pend | d_pend);
    if (!if_pend && !d_pend) begin
      @(posedge clk); #1;
      chk("idle_noreq", mem_req, 0);
      return;
    end
    g_d = d_pend && (!if_pend || last_if);
    last_if = !g_d;
    @(posedge clk); #1;
    n = 1;
    to = 0;
    forever begin
      chk("busy_req", mem_req, 1);
      chk("busy_addr", mem_addr, g_d ? d_a : if_a);
      chk("busy_we", mem_we, g_d & d_w);
      if (g_d && d_w) chk("busy_wdata", mem_wdata, d_wd);
      chk("busy_stall", stall, 1);
      chk("busy_valids", {if_valid, d_valid}, 0);
      if (n == lat) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      if (n == lat) break;
      if (n == TO) begin
        to = 1;
        break;
      end
      n++;
    end
    // Response cycle: a stray mem_ready here must be ignored.
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    if (to) tmo_exp = 1;
    if (g_d) begin
      if (to) d_exp = 0;
      else if (!d_w) d_exp = rd;
    end else begin
      if_exp = to ? 32'h0 : rd;
    end
    #1;
    chk("resp_req", mem_req, 0);
    chk("resp_if_valid", if_valid, !g_d);
    chk("resp_d_valid", d_valid, g_d);
    chk("resp_if_rdata", if_rdata, if_exp);
    chk("resp_d_rdata", d_rdata, d_exp);
    chk("resp_tmo", timeout_err, tmo_exp);
    chk("resp_stall", stall, g_d ? if_pend : d_pend);
    if (g_d) d_pend = 0;
    else if_pend = 0;
    drive_reqs();
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("post_valids", {if_valid, d_valid}, 0);
    chk("post_if_rdata", if_rdata, if_exp);
  endtask

  task automatic flush();
    for (int k = 0; k < 4 && (if_pend || d_pend); k++) do_round(1, $urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    if_pend = 0; d_pend = 0; d_w = 0;
    if_a = 0; d_a = 0; d_wd = 0;
    drive_reqs();
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valids", {if_valid, d_valid}, 0);
    chk("rst_rdata", if_rdata | d_rdata, 0);
    chk("rst_tmo", timeout_err, 0);
    @(negedge clk) reset = 1'b1;

    // Reset in the middle of a fetch.
    @(posedge clk); #1;
    if_req = 1'b1;
    if_addr = 32'h10;
    @(posedge clk); #1;
    chk("mid_busy_req", mem_req, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", if_valid, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rel_req", mem_req, 0);
    chk("mid_rel_valid", if_valid, 0);
    last_if = 1; if_exp = 0; d_exp = 0; tmo_exp = 0;

    // Single fetch.
    if_pend = 1; if_a = 32'h10;
    do_round(1, 32'h00500093);

    // Store and fetch together: data goes first.
    d_pend = 1; d_w = 1; d_a = 32'h40; d_wd = 32'hDEADBEEF;
    if_pend = 1; if_a = 32'h20;
    do_round(2, 32'h11111111);
    do_round(1, 32'h22222222);

    // Both requesters continuously busy.
    for (int i = 0; i < 4; i++) begin
      if (!if_pend) begin if_pend = 1; if_a = 32'h100 + i; end
      if (!d_pend) begin d_pend = 1; d_w = 0; d_a = 32'h200 + 4 * i; end
      do_round(1 + i, $urandom);
    end
    flush();

    // Slow load at the timeout boundary, then an aborted fetch.
    d_pend = 1; d_w = 0; d_a = 32'h44;
    do_round(6, 32'h12345678);
    if_pend = 1; if_a = 32'h80;
    do_round(0, 32'h0);

    for (int r = 0; r < 200; r++) begin
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1; if_a = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend = 1; d_w = 1'($urandom_range(0, 1)); d_a = $urandom; d_wd = $urandom;
      end
      do_round($urandom_range(0, TO + 2), $urandom);
    end
    flush();

    reset = 1'b0;
    #1;
    chk("final_rst_tmo", timeout_err, 0);
    chk("final_rst_req", mem_req, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
